// File: rtl/fetch_decode_regs.sv
// F and D pipeline registers of the Y86-64 five-stage pipeline, with
// saturating stall/bubble performance counters and a sticky control-conflict flag.
module fetch_decode_regs #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             F_stall,
   input  logic             D_stall,
   input  logic             D_bubble,
   input  logic [63:0]      f_predPC,
   input  logic [0:3]       f_stat,
   input  logic [3:0]       f_icode,
   input  logic [3:0]       f_ifun,
   input  logic [3:0]       f_rA,
   input  logic [3:0]       f_rB,
   input  logic [63:0]      f_valC,
   input  logic [63:0]      f_valP,
   output logic [63:0]      F_predPC,
   output logic [0:3]       D_stat,
   output logic [3:0]       D_icode,
   output logic [3:0]       D_ifun,
   output logic [3:0]       D_rA,
   output logic [3:0]       D_rB,
   output logic [63:0]      D_valC,
   output logic [63:0]      D_valP,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt,
   output logic             ctrl_err
);

   typedef struct packed {
      logic [0:3]  stat;
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [3:0]  rA;
      logic [3:0]  rB;
      logic [63:0] valC;
      logic [63:0] valP;
   } d_reg_t;

   // A bubble is a NOP with no register operands and AOK status.
   localparam d_reg_t D_BUBBLE = '{
      stat:  4'b1000,
      icode: 4'h1,
      ifun:  4'h0,
      rA:    4'hF,
      rB:    4'hF,
      valC:  64'h0,
      valP:  64'h0
   };

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [63:0]      pred_pc_q,    pred_pc_d;
   d_reg_t           d_q,          d_d;
   logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
   logic             ctrl_err_q,   ctrl_err_d;
   logic             bubble_load;
   d_reg_t           fetched;

   assign fetched = '{
      stat:  f_stat,
      icode: f_icode,
      ifun:  f_ifun,
      rA:    f_rA,
      rB:    f_rB,
      valC:  f_valC,
      valP:  f_valP
   };

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      pred_pc_d    = pred_pc_q;
      d_d          = d_q;
      bubble_load  = 1'b0;
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      ctrl_err_d   = ctrl_err_q;

      if (!F_stall) begin
         pred_pc_d = f_predPC;
      end

      // Stall outranks bubble, so a conflicting request never loads a bubble.
      if (!D_stall) begin
         if (D_bubble) begin
            d_d         = D_BUBBLE;
            bubble_load = 1'b1;
         end else begin
            d_d = fetched;
         end
      end

      if (D_stall && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
      if (bubble_load && (bubble_cnt_q != CNT_MAX)) begin
         bubble_cnt_d = bubble_cnt_q + CNT_ONE;
      end

      if (D_stall && D_bubble) begin
         ctrl_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pred_pc_q    <= RESET_PC;
         d_q          <= D_BUBBLE;
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
         ctrl_err_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
         pred_pc_q    <= pred_pc_d;
         d_q          <= d_d;
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
         ctrl_err_q   <= ctrl_err_d;
      end
   end

   assign F_predPC   = pred_pc_q;
   assign D_stat     = d_q.stat;
   assign D_icode    = d_q.icode;
   assign D_ifun     = d_q.ifun;
   assign D_rA       = d_q.rA;
   assign D_rB       = d_q.rB;
   assign D_valC     = d_q.valC;
   assign D_valP     = d_q.valP;
   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
   assign ctrl_err   = ctrl_err_q;

endmodule

// File: tb/tb_fetch_decode_regs.sv
// Directed bench for fetch_decode_regs: a default-width instance plus a
// CNT_W=4 instance sharing the same stimulus for counter saturation.
module tb_fetch_decode_regs;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        F_stall, D_stall, D_bubble;
   logic [63:0] f_predPC, f_valC, f_valP;
   logic [0:3]  f_stat;
   logic [3:0]  f_icode, f_ifun, f_rA, f_rB;

   logic [63:0] F_predPC, D_valC, D_valP;
   logic [0:3]  D_stat;
   logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
   logic [31:0] stall_cnt, bubble_cnt;
   logic        ctrl_err;

   logic [63:0] s_F_predPC, s_D_valC, s_D_valP;
   logic [0:3]  s_D_stat;
   logic [3:0]  s_D_icode, s_D_ifun, s_D_rA, s_D_rB;
   logic [3:0]  s_stall_cnt, s_bubble_cnt;
   logic        s_ctrl_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fetch_decode_regs u_dut (
      .clk(clk), .rst_n(rst_n), .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
      .f_predPC(f_predPC), .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun),
      .f_rA(f_rA), .f_rB(f_rB), .f_valC(f_valC), .f_valP(f_valP),
      .F_predPC(F_predPC), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
      .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP),
      .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .ctrl_err(ctrl_err)
   );

   fetch_decode_regs #(.RESET_PC(64'hDEAD_0000), .CNT_W(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
      .f_predPC(f_predPC), .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun),
      .f_rA(f_rA), .f_rB(f_rB), .f_valC(f_valC), .f_valP(f_valP),
      .F_predPC(s_F_predPC), .D_stat(s_D_stat), .D_icode(s_D_icode), .D_ifun(s_D_ifun),
      .D_rA(s_D_rA), .D_rB(s_D_rB), .D_valC(s_D_valC), .D_valP(s_D_valP),
      .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt), .ctrl_err(s_ctrl_err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ctrl(input logic fs, input logic ds, input logic db);
      F_stall  = fs;
      D_stall  = ds;
      D_bubble = db;
   endtask

   task automatic fetch(input logic [0:3] st, input logic [3:0] ic, input logic [3:0] fn,
                        input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vc,
                        input logic [63:0] vp, input logic [63:0] pp);
      f_stat   = st;
      f_icode  = ic;
      f_ifun   = fn;
      f_rA     = ra;
      f_rB     = rb;
      f_valC   = vc;
      f_valP   = vp;
      f_predPC = pp;
   endtask

   task automatic check_bubble(input string tag);
      check({tag, "_icode"}, 64'(D_icode), 64'h1);
      check({tag, "_ifun"},  64'(D_ifun),  64'h0);
      check({tag, "_rA"},    64'(D_rA),    64'hF);
      check({tag, "_rB"},    64'(D_rB),    64'hF);
      check({tag, "_stat"},  64'(D_stat),  64'h8);
      check({tag, "_valC"},  D_valC,       64'h0);
      check({tag, "_valP"},  D_valP,       64'h0);
   endtask

   initial begin
      rst_n = 1'b0;
      ctrl(1'b0, 1'b0, 1'b0);
      fetch(4'b1000, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0, 64'h0);
      tick();
      tick();

      check_bubble("rst");
      check("rst_pc",     F_predPC,             64'h0);
      check("rst_scnt",   64'(stall_cnt),       64'h0);
      check("rst_bcnt",   64'(bubble_cnt),      64'h0);
      check("rst_err",    64'(ctrl_err),        64'h0);
      check("rst_pc_sat", s_F_predPC,           64'hDEAD_0000);

      // Normal flow
      #2 rst_n = 1'b1;
      fetch(4'b1000, 4'h3, 4'h0, 4'hF, 4'h2, 64'h10, 64'hA, 64'hA);
      tick();
      check("nrm_icode", 64'(D_icode), 64'h3);
      check("nrm_rA",    64'(D_rA),    64'hF);
      check("nrm_rB",    64'(D_rB),    64'h2);
      check("nrm_valC",  D_valC,       64'h10);
      check("nrm_valP",  D_valP,       64'hA);
      check("nrm_pc",    F_predPC,     64'hA);
      check("nrm_stat",  64'(D_stat),  64'h8);

      // Load-use stall: f_* change but F and D hold
      ctrl(1'b1, 1'b1, 1'b0);
      fetch(4'b0100, 4'h5, 4'h2, 4'h1, 4'h3, 64'h20, 64'h14, 64'h14);
      tick();
      check("stl_icode", 64'(D_icode),   64'h3);
      check("stl_rB",    64'(D_rB),      64'h2);
      check("stl_valC",  D_valC,         64'h10);
      check("stl_pc",    F_predPC,       64'hA);
      check("stl_scnt",  64'(stall_cnt), 64'h1);
      ctrl(1'b0, 1'b0, 1'b0);
      tick();
      check("rel_icode", 64'(D_icode),   64'h5);
      check("rel_ifun",  64'(D_ifun),    64'h2);
      check("rel_rA",    64'(D_rA),      64'h1);
      check("rel_rB",    64'(D_rB),      64'h3);
      check("rel_valC",  D_valC,         64'h20);
      check("rel_valP",  D_valP,         64'h14);
      check("rel_stat",  64'(D_stat),    64'h4);
      check("rel_pc",    F_predPC,       64'h14);
      check("rel_scnt",  64'(stall_cnt), 64'h1);

      // Mispredict bubble; F keeps updating
      ctrl(1'b0, 1'b0, 1'b1);
      fetch(4'b1000, 4'h6, 4'h1, 4'h4, 4'h5, 64'h99, 64'h77, 64'h20);
      tick();
      check_bubble("bub");
      check("bub_bcnt", 64'(bubble_cnt), 64'h1);
      check("bub_pc",   F_predPC,        64'h20);

      // ret drain: F stalled while D bubbles
      ctrl(1'b1, 1'b0, 1'b1);
      fetch(4'b1000, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h30, 64'h30);
      tick();
      check_bubble("ret");
      check("ret_bcnt", 64'(bubble_cnt), 64'h2);
      check("ret_pc",   F_predPC,        64'h20);

      ctrl(1'b0, 1'b0, 1'b0);
      fetch(4'b0001, 4'h6, 4'h1, 4'h2, 4'h3, 64'h0, 64'h22, 64'h22);
      tick();
      check("ld_icode", 64'(D_icode), 64'h6);
      check("ld_ifun",  64'(D_ifun),  64'h1);
      check("ld_stat",  64'(D_stat),  64'h1);
      check("ld_pc",    F_predPC,     64'h22);

      // Conflict: stall wins, flag sticks
      ctrl(1'b0, 1'b1, 1'b1);
      fetch(4'b0010, 4'h7, 4'h0, 4'h8, 4'h9, 64'h40, 64'h40, 64'h40);
      tick();
      check("cfl_icode", 64'(D_icode),    64'h6);
      check("cfl_stat",  64'(D_stat),     64'h1);
      check("cfl_err",   64'(ctrl_err),   64'h1);
      check("cfl_bcnt",  64'(bubble_cnt), 64'h2);
      check("cfl_scnt",  64'(stall_cnt),  64'h2);
      check("cfl_pc",    F_predPC,        64'h40);
      ctrl(1'b0, 1'b0, 1'b0);
      tick();
      check("cfl2_icode", 64'(D_icode),  64'h7);
      check("cfl2_stat",  64'(D_stat),   64'h2);
      check("cfl2_err",   64'(ctrl_err), 64'h1);
      tick();
      check("cfl3_err",   64'(ctrl_err), 64'h1);

      // Saturation: 4-bit counter starts at 2 and clamps at F
      ctrl(1'b0, 1'b1, 1'b0);
      for (int i = 1; i <= 20; i++) begin
         tick();
         check($sformatf("sat_%0d", i), 64'(s_stall_cnt), (2 + i > 15) ? 64'hF : 64'(2 + i));
      end
      check("sat_main_scnt", 64'(stall_cnt),    64'd22);
      check("sat_bcnt",      64'(s_bubble_cnt), 64'h2);
      check("sat_icode",     64'(D_icode),      64'h7);

      // Asynchronous reset mid-cycle with D holding icode=3
      ctrl(1'b0, 1'b0, 1'b0);
      fetch(4'b1000, 4'h3, 4'h0, 4'h1, 4'h2, 64'h55, 64'h66, 64'h66);
      tick();
      check("pre_icode", 64'(D_icode), 64'h3);
      #2 rst_n = 1'b0;
      #1;
      check_bubble("arst");
      check("arst_pc",     F_predPC,          64'h0);
      check("arst_scnt",   64'(stall_cnt),    64'h0);
      check("arst_bcnt",   64'(bubble_cnt),   64'h0);
      check("arst_err",    64'(ctrl_err),     64'h0);
      check("arst_err_s",  64'(s_ctrl_err),   64'h0);
      check("arst_scnt_s", 64'(s_stall_cnt),  64'h0);
      check("arst_pc_s",   s_F_predPC,        64'hDEAD_0000);
      ctrl(1'b1, 1'b1, 1'b1);
      tick();
      check("hold_icode", 64'(D_icode),   64'h1);
      check("hold_scnt",  64'(stall_cnt), 64'h0);
      check("hold_err",   64'(ctrl_err),  64'h0);

      ctrl(1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b1;
      tick();
      check("post_icode", 64'(D_icode), 64'h3);
      check("post_pc",    F_predPC,     64'h66);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_decode_regs.md
Name: fetch_decode_regs

Overview:
- Holds the F pipeline register (predicted PC) and the D pipeline register (fetched instruction fields) of the Y86-64 five-stage pipeline.
- Consumes the F_stall, D_stall and D_bubble outputs of the pipeline control unit.
- Feeds D_icode to the control unit and the D fields to the decode stage.
- Also keeps saturating performance counters for stall and bubble cycles, and a sticky control-conflict flag.

Parameters:
- RESET_PC, 64'h0, value loaded into F_predPC on reset.
- CNT_W, 32, width of the stall/bubble performance counters.

Ports:
- clk  input  1  pipeline clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- F_stall  input  1  hold the F register.
- D_stall  input  1  hold the D register.
- D_bubble  input  1  load a NOP bubble into the D register.
- f_predPC  input  64  next predicted PC from fetch.
- f_stat  input  [0:3]  fetch status, one-hot: AOK=1000, HLT=0100, ADR=0010, INS=0001.
- f_icode  input  4  fetched icode.
- f_ifun  input  4  fetched ifun.
- f_rA  input  4  fetched rA.
- f_rB  input  4  fetched rB.
- f_valC  input  64  fetched constant.
- f_valP  input  64  fetched next-sequential PC.
- F_predPC  output  64  registered predicted PC.
- D_stat  output  [0:3]  registered status.
- D_icode  output  4  registered icode.
- D_ifun  output  4  registered ifun.
- D_rA  output  4  registered rA.
- D_rB  output  4  registered rB.
- D_valC  output  64  registered valC.
- D_valP  output  64  registered valP.
- stall_cnt  output  CNT_W  cycles with D_stall=1.
- bubble_cnt  output  CNT_W  cycles where a D bubble was inserted.
- ctrl_err  output  1  sticky: D_stall and D_bubble seen together.

Behaviour:
- All state updates on the rising clk edge.
- rst_n low asynchronously forces:
  - F_predPC=RESET_PC.
  - D register to the bubble value: stat=1000, icode=4'h1, ifun=0, rA=rB=4'hF, valC=0, valP=0.
  - stall_cnt=0, bubble_cnt=0, ctrl_err=0.
  - Release is synchronous to the next edge. Reset mid-operation discards all held state.
- F register:
  - F_stall=0: F_predPC<=f_predPC.
  - F_stall=1: hold.
- D register, one-cycle latency from f_* inputs. Priority order:
  - D_stall=1: hold all D fields, regardless of D_bubble.
  - else D_bubble=1: load the bubble value.
  - else: load the f_* fields.
- Simultaneous D_stall and D_bubble:
  - Stall wins.
  - ctrl_err<=1 and stays 1 until reset.
  - bubble_cnt not incremented.
- Counters:
  - stall_cnt increments on every edge with D_stall=1.
  - bubble_cnt increments on every edge where a bubble is actually loaded.
  - Both saturate at all-ones; no wrap-around.
- F_stall and D_stall are independent. F_stall=1 with D_stall=0 is legal: it is the ret/halt-drain case, where D normally bubbles.
- f_stat passes through unmodified. Non-AOK status is not acted on here; the block only registers it.
- No combinational path from inputs to outputs. Every output is a flop.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with D loaded (icode=3) -> outputs change immediately with no clock edge: F_predPC=RESET_PC, D_icode=1, D_rA=D_rB=F, D_stat=1000, counters 0, ctrl_err=0.
- Normal flow: all controls 0; f_icode=3, f_rB=2, f_valC=64'h10, f_valP=64'hA, f_predPC=64'hA -> after one edge D_icode=3, D_rB=2, D_valC=10h, D_valP=Ah, F_predPC=Ah.
- Load-use stall: F_stall=D_stall=1 for one cycle while f_* change -> D fields and F_predPC unchanged; stall_cnt=1; next cycle with controls 0 loads the new f_* values.
- Mispredict/ret bubble: D_bubble=1, F_stall=0, f_icode=6 -> D_icode=1, D_rA=D_rB=F, D_valC=0; bubble_cnt=1; F_predPC still updates.
- Conflict: D_stall=D_bubble=1 -> D holds, ctrl_err=1, bubble_cnt unchanged, stall_cnt+1; ctrl_err remains 1 after controls drop, clears only on rst_n.
- Saturation: CNT_W=4, hold D_stall=1 for 20 cycles -> stall_cnt reaches 4'hF and stays at 4'hF.
